// File: rtl/fifo_drain_ctrl.sv
// Drain controller: pops a source FIFO and pushes a downstream FIFO through a two-stage pipeline.
// Optional macro FIFO_DRAIN_COUNT_EN adds the word_count output (wrapping count of pushes).
module fifo_drain_ctrl #(
    parameter int DATA_W = 12,
    parameter int UMB_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UMB_W-1:0]  umbral_AF_in,
    input  logic [UMB_W-1:0]  umbral_AE_in,
    input  logic              src_empty,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_pop,
    input  logic              dst_almost_full,
    input  logic              dst_full,
    output logic              dst_push,
    output logic [DATA_W-1:0] dst_data,
    output logic [UMB_W-1:0]  umbral_AF_out,
    output logic [UMB_W-1:0]  umbral_AE_out,
    output logic [3:0]        state,
    output logic              idle,
    output logic              error
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    output logic [7:0]        word_count
`endif
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t            state_reg, state_next;
    logic              v1_reg, v2_reg;
    logic [DATA_W-1:0] data_reg;
    logic [UMB_W-1:0]  af_reg, ae_reg;
    logic              error_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // init overrides every other transition out of IDLE/ACTIVE
    always_comb begin
        state_next = state_reg;
        src_pop    = 1'b0;
        case (state_reg)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT:   state_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init)
                    state_next = ST_INIT;
                else if (!src_empty)
                    state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)
                    state_next = ST_INIT;
                else if (src_empty && !v1_reg && !v2_reg)
                    state_next = ST_IDLE;
                src_pop = !src_empty && !dst_almost_full && !init;
            end
            default:   state_next = ST_RESET;
        endcase
    end

    // Pipeline runs independently of the FSM so in-flight words always finish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            data_reg  <= '0;
            af_reg    <= '0;
            ae_reg    <= '0;
            error_reg <= 1'b0;
        end else begin
            v1_reg <= src_pop;
            v2_reg <= v1_reg;
            if (v1_reg)
                data_reg <= src_data;
            if (state_reg == ST_INIT) begin
                af_reg <= umbral_AF_in;
                ae_reg <= umbral_AE_in;
            end
            if (v2_reg && dst_full)
                error_reg <= 1'b1;
        end
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [7:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= 8'd0;
        end else if (state_next == ST_INIT && state_reg != ST_INIT) begin
            count_reg <= 8'd0;
        end else if (v2_reg) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign word_count = count_reg;
`endif

    assign state         = state_reg;
    assign dst_push      = v2_reg;
    assign dst_data      = data_reg;
    assign umbral_AF_out = af_reg;
    assign umbral_AE_out = ae_reg;
    assign error         = error_reg;
    assign idle          = (state_reg == ST_IDLE) && !v1_reg && !v2_reg;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: source FIFO model, scoreboard of expected downstream words.
module tb_fifo_drain_ctrl;
    localparam int DATA_W = 12;
    localparam int UMB_W  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, init, src_empty, dst_almost_full, dst_full;
    logic [UMB_W-1:0]  af_in, ae_in;
    logic [DATA_W-1:0] src_data;
    logic              src_pop, dst_push, idle, error;
    logic [DATA_W-1:0] dst_data;
    logic [UMB_W-1:0]  af_out, ae_out;
    logic [3:0]        state;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [7:0]        word_count;
`endif

    fifo_drain_ctrl #(.DATA_W(DATA_W), .UMB_W(UMB_W)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_AF_in(af_in), .umbral_AE_in(ae_in),
        .src_empty(src_empty), .src_data(src_data), .src_pop(src_pop),
        .dst_almost_full(dst_almost_full), .dst_full(dst_full),
        .dst_push(dst_push), .dst_data(dst_data),
        .umbral_AF_out(af_out), .umbral_AE_out(ae_out),
        .state(state), .idle(idle), .error(error)
`ifdef FIFO_DRAIN_COUNT_EN
        , .word_count(word_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pops, pushes, cyc, pop_cyc, push_first, push_last;
    logic pop_d;
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(posedge clk) pop_d <= src_pop;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_stats();
        pops = 0; pushes = 0; pop_cyc = -1; push_first = -1; push_last = -1;
    endtask

    task automatic load(input logic [DATA_W-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        src_empty = 1'b0;
    endtask

    // One clock: source model reacts to pops after the edge, monitor scores pushes at negedge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pop_d === 1'b1) begin
            pops++;
            if (pop_cyc < 0) pop_cyc = cyc;
            if (src_q.size() > 0) src_data = src_q.pop_front();
        end
        src_empty = (src_q.size() == 0);
        @(negedge clk);
        if (dst_push === 1'b1) begin
            pushes++;
            if (push_first < 0) push_first = cyc;
            push_last = cyc;
            $display("push cyc=%0d data=%03h", cyc, dst_data);
            if (exp_q.size() == 0)
                chk("unexpected_push", 32'(dst_data), 32'hFFFF_FFFF);
            else
                chk("dst_data", 32'(dst_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_idle(input int bound);
        int n;
        tick();
        tick();
        n = 0;
        while (idle !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pops < target && n < 20) begin
            tick();
            n++;
        end
        chk("pops_reached", pops, target);
    endtask

    initial begin
        cyc = 0;
        clr_stats();
        reset = 1'b1; init = 1'b0; src_empty = 1'b1; src_data = '0;
        dst_almost_full = 1'b0; dst_full = 1'b0; af_in = 3'd7; ae_in = 3'd0;
        #2;
        chk("rst_state", 32'(state), 32'h1);
        chk("rst_pop", 32'(src_pop), 32'd0);
        chk("rst_push", 32'(dst_push), 32'd0);
        chk("rst_af", 32'(af_out), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);

        // Bring-up: RESET -> INIT -> IDLE, thresholds 7/0
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("bringup_init", 32'(state), 32'h2);
        tick();
        chk("bringup_idle", 32'(state), 32'h4);
        chk("bringup_af", 32'(af_out), 32'd7);
        chk("bringup_ae", 32'(ae_out), 32'd0);
        chk("bringup_idle_flag", 32'(idle), 32'd1);

        // Two words, back to back
        clr_stats();
        load(12'h00A);
        load(12'h00B);
        run_idle(20);
        chk("two_pops", pops, 2);
        chk("two_pushes", pushes, 2);
        chk("latency", push_first - pop_cyc, 1);
        chk("back_to_back", push_last - push_first, 1);
        chk("two_state", 32'(state), 32'h4);
        chk("two_drained", exp_q.size(), 0);

        // Backpressure after the second pop
        clr_stats();
        load(12'h00C); load(12'h00D); load(12'h00E); load(12'h00F);
        wait_pops(2);
        dst_almost_full = 1'b1;
        #1;
        chk("af_pop_stop", 32'(src_pop), 32'd0);
        repeat (5) tick();
        chk("af_pops", pops, 2);
        chk("af_pushes", pushes, 2);
        dst_almost_full = 1'b0;
        run_idle(20);
        chk("af_total_pops", pops, 4);
        chk("af_total_pushes", pushes, 4);
        chk("af_drained", exp_q.size(), 0);

        // Reset with a word in the first pipeline stage
        clr_stats();
        load(12'h111);
        wait_pops(1);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 32'h1);
        chk("mid_rst_push", 32'(dst_push), 32'd0);
        chk("mid_rst_data", 32'(dst_data), 32'd0);
        chk("mid_rst_af", 32'(af_out), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd0);
        exp_q.delete();
        src_q.delete();
        src_empty = 1'b1;
        repeat (2) tick();
        chk("mid_rst_no_push", pushes, 0);
        reset = 1'b0;
        tick();
        chk("restart_init", 32'(state), 32'h2);
        tick();
        chk("restart_idle", 32'(state), 32'h4);
        chk("restart_af", 32'(af_out), 32'd7);

        // init while ACTIVE with one word in flight
        clr_stats();
        load(12'h0C1);
        load(12'h0C2);
        wait_pops(1);
        init = 1'b1; af_in = 3'd3; ae_in = 3'd1;
        #1;
        chk("init_pop_stop", 32'(src_pop), 32'd0);
        void'(src_q.pop_back());
        void'(exp_q.pop_back());
        src_empty = (src_q.size() == 0);
        tick();
        chk("init_state", 32'(state), 32'h2);
        tick();
        chk("init_af", 32'(af_out), 32'd3);
        chk("init_ae", 32'(ae_out), 32'd1);
        chk("init_inflight_pushed", pushes, 1);
        chk("init_drained", exp_q.size(), 0);
        init = 1'b0;
        tick();
        chk("init_exit_state", 32'(state), 32'h4);
        chk("init_exit_idle", 32'(idle), 32'd1);

        // Overflow: push while downstream full, sticky through init
        chk("err_before", 32'(error), 32'd0);
        clr_stats();
        dst_full = 1'b1;
        load(12'h0E5);
        run_idle(20);
        chk("err_push", pushes, 1);
        chk("err_set", 32'(error), 32'd1);
        dst_full = 1'b0;
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_state", 32'(state), 32'h4);

`ifdef FIFO_DRAIN_COUNT_EN
        chk("cnt_cleared", 32'(word_count), 32'd0);
        clr_stats();
        for (int i = 0; i < 257; i++) load(DATA_W'(i + 16));
        run_idle(600);
        chk("cnt_pushes", pushes, 257);
        chk("cnt_wrap", 32'(word_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
